ai_stream_unpacker: RTL and testbench
=====================================

Name: ai_stream_unpacker

Overview:
- Downstream consumer of the AI DMA loader's 32-bit Avalon-ST packet stream.
- Each accepted word carries four packed 8-bit audio samples. The block buffers words in a small FIFO and unpacks them into one byte per handshake for the feature-extraction front end.
- Checks packet framing: stray start-of-packet, and packet length against the programmed frame length.
- Raises a one-cycle frame_done pulse after the last byte of a packet is consumed.

Parameters:
- FIFO_DEPTH, 16, word FIFO depth; must be a power of 2, minimum 4.
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; the block is reset on any rising clk edge where rst==0.
- enable  in  1  input side accepts words only while 1.
- expected_len  in  16  expected packet length in bytes; a multiple of 4.
- avs_s1_valid  in  1  sink valid.
- avs_s1_data  in  32  packed samples; byte[7:0] is the earliest sample, byte[31:24] the latest.
- avs_s1_startofpacket  in  1  first word of packet.
- avs_s1_endofpacket  in  1  last word of packet.
- avs_s1_ready  out  1  sink ready.
- smp_valid  out  1  sample valid.
- smp_data  out  8  sample byte.
- smp_first  out  1  first byte of packet.
- smp_last  out  1  last byte of packet.
- smp_ready  in  1  downstream ready.
- frame_done  out  1  one-cycle pulse, packet fully drained.
- err_sop  out  1  one-cycle pulse, framing error.
- err_len  out  1  one-cycle pulse, length mismatch.
- err_cnt  out  8  error count, saturating.

Behaviour:
- Reset (rst==0 at a clk edge) clears FIFO pointers, byte index, FSM, byte counter and err_cnt.
  - All outputs read 0 after reset; avs_s1_ready is 0 during reset.
  - Reset mid-packet discards buffered words; no frame_done is produced.
- Word accept: a word is accepted when avs_s1_valid && avs_s1_ready.
  - avs_s1_ready = enable && !fifo_full.
  - No write-while-full, even if a pop occurs in the same cycle.
  - FIFO entry is {eop, sop, data}, 34 bits.
- Input FSM, state S_IDLE:
  - Accepted word with sop=1: write it, byte counter = 4, go to S_RECV.
  - If that word also has eop=1: compare 4 with expected_len (mismatch pulses err_len) and stay in S_IDLE.
  - Accepted word with sop=0: drop it (not written), pulse err_sop.
- Input FSM, state S_RECV: every accepted word is written and the counter increments by 4, wrapping modulo 2^16.
  - Word with sop=1: pulse err_sop, restart counter at 4, write the word as a new packet start.
  - Word with eop=1: if counter+4 != expected_len, pulse err_len; return to S_IDLE.
- enable low: ready is 0, FSM and counter hold, output side keeps draining.
- Output side: fed combinationally from the FIFO head, using a 2-bit byte_idx.
  - smp_valid = !fifo_empty.
  - smp_data = head.data[8*byte_idx +: 8].
  - smp_first = head.sop && byte_idx==0.
  - smp_last = head.eop && byte_idx==3.
  - On smp_valid && smp_ready: byte_idx increments; at byte_idx==3 it wraps to 0 and the head is popped.
  - Outputs stay stable while smp_valid && !smp_ready.
- Latency: a word accepted at edge N presents byte 0 from cycle N+1. Sustained throughput is 1 byte/cycle, so the input is accepted at most 1 word per 4 cycles in steady state.
- frame_done: registered; pulses 1 cycle after the handshake of a byte with smp_last=1.
- err_cnt: increments by 1 per err_sop or err_len pulse, saturating at 255. If both pulse in the same cycle it increments by 2, still saturating.

Decomposition:
- Package ai_stream_pkg holds:
  - input FSM state enum {S_IDLE, S_RECV};
  - constants BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, FIFO_ENTRY_W=34.
- One sub-module, ai_word_fifo:
  - synchronous FIFO with registered write and combinational head read;
  - full/empty derived from FIFO_AW+1-bit pointers;
  - active-low synchronous reset.

Test Plan:
- Packet of 2 words (0x44332211 sop, 0x88776655 eop), expected_len=8, smp_ready=1 → bytes 11,22,33,44,55,66,77,88 on consecutive cycles; smp_first on 0x11, smp_last on 0x88; frame_done 1 cycle after 0x88; no errors.
- Word without sop in S_IDLE → word dropped, err_sop pulse, err_cnt=1, no smp_valid.
- Packet of 3 words with expected_len=8 → err_len pulse on the eop word; all 12 bytes still delivered; frame_done still fires.
- smp_ready held 0, 17 words offered with FIFO_DEPTH=16 → exactly 16 accepted, avs_s1_ready low on the 17th. Release smp_ready → bytes drain in order and ready reasserts after the first pop.
- Reset asserted mid-packet with 3 words buffered → next cycle smp_valid=0 and err_cnt=0; a new sop packet then streams correctly.
- 300 framing errors → err_cnt saturates at 255.

Source files
------------

// File: rtl/ai_stream_pkg.sv
// Shared types and constants for the AI stream unpacker: input FSM states,
// FIFO entry layout and the saturating error-count helper.
package ai_stream_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;
   localparam int FIFO_ENTRY_W   = 34;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RECV = 1'b1
   } in_state_e;

   typedef struct packed {
      logic              eop;
      logic              sop;
      logic [WORD_W-1:0] data;
   } fifo_entry_t;

   function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, base} + {7'd0, inc};
      if (sum > 9'd255) begin
         return 8'd255;
      end else begin
         return sum[7:0];
      end
   endfunction

endpackage

// File: rtl/ai_word_fifo.sv
// Word FIFO: registered write, combinational head read, full/empty taken
// from pointers one bit wider than the address.
module ai_word_fifo
   import ai_stream_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    wr_en_i,
   input  logic [FIFO_ENTRY_W-1:0] wr_data_i,
   input  logic                    rd_en_i,
   output logic [FIFO_ENTRY_W-1:0] rd_data_o,
   output logic                    full_o,
   output logic                    empty_o
);

   logic [FIFO_ENTRY_W-1:0] mem_q [DEPTH];
   logic [AW:0]             wr_ptr_q, wr_ptr_d;
   logic [AW:0]             rd_ptr_q, rd_ptr_d;
   logic                    do_wr_s, do_rd_s;

   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign do_wr_s   = wr_en_i && !full_o;
   assign do_rd_s   = rd_en_i && !empty_o;
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_wr_s) begin
         wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (do_rd_s) begin
         rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Pointer registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk_i) begin
      if (do_wr_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

endmodule

// File: rtl/ai_stream_unpacker.sv
// Avalon-ST word sink that buffers packed 4-sample words and emits one byte
// per handshake, with packet framing and length checking.
module ai_stream_unpacker
   import ai_stream_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [15:0] expected_len,
   input  logic        avs_s1_valid,
   input  logic [31:0] avs_s1_data,
   input  logic        avs_s1_startofpacket,
   input  logic        avs_s1_endofpacket,
   output logic        avs_s1_ready,
   output logic        smp_valid,
   output logic [7:0]  smp_data,
   output logic        smp_first,
   output logic        smp_last,
   input  logic        smp_ready,
   output logic        frame_done,
   output logic        err_sop,
   output logic        err_len,
   output logic [7:0]  err_cnt
);

   fifo_entry_t head_s, wr_entry_s;
   logic        fifo_full_s, fifo_empty_s;
   logic        wr_en_s, accept_s, smp_hs_s, pop_s;
   in_state_e   state_q, state_d;
   logic [15:0] cnt_q, cnt_d, cnt_next_s;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic        err_sop_q, err_sop_d;
   logic        err_len_q, err_len_d;
   logic        frame_done_q, frame_done_d;
   logic [7:0]  err_cnt_q, err_cnt_d;

   ai_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk_i     (clk),
      .rst_ni    (rst),
      .wr_en_i   (wr_en_s),
      .wr_data_i (wr_entry_s),
      .rd_en_i   (pop_s),
      .rd_data_o (head_s),
      .full_o    (fifo_full_s),
      .empty_o   (fifo_empty_s)
   );

   // Ready is also held low while reset is applied
   assign avs_s1_ready = rst && enable && !fifo_full_s;
   assign accept_s     = avs_s1_valid && avs_s1_ready;
   assign wr_entry_s   = {avs_s1_endofpacket, avs_s1_startofpacket, avs_s1_data};
   assign smp_valid    = !fifo_empty_s;
   assign smp_hs_s     = smp_valid && smp_ready;
   assign pop_s        = smp_hs_s && (byte_idx_q == 2'd3);
   assign cnt_next_s   = (avs_s1_startofpacket ? 16'd0 : cnt_q) + 16'd4;

   // Output byte selection from the FIFO head
   always_comb begin
      smp_data  = 8'd0;
      smp_first = 1'b0;
      smp_last  = 1'b0;
      if (smp_valid) begin
         case (byte_idx_q)
            2'd0:    smp_data = head_s.data[7:0];
            2'd1:    smp_data = head_s.data[15:8];
            2'd2:    smp_data = head_s.data[23:16];
            2'd3:    smp_data = head_s.data[31:24];
            default: smp_data = 8'd0;
         endcase
         smp_first = head_s.sop && (byte_idx_q == 2'd0);
         smp_last  = head_s.eop && (byte_idx_q == 2'd3);
      end else begin
         smp_data  = 8'd0;
      end
   end

   // Input framing FSM, byte counter and error detection
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wr_en_s   = 1'b0;
      err_sop_d = 1'b0;
      err_len_d = 1'b0;
      if (accept_s) begin
         case (state_q)
            S_IDLE: begin
               if (avs_s1_startofpacket) begin
                  wr_en_s = 1'b1;
                  cnt_d   = 16'd4;
                  if (avs_s1_endofpacket) begin
                     err_len_d = (expected_len != 16'd4);
                     state_d   = S_IDLE;
                  end else begin
                     state_d   = S_RECV;
                  end
               end else begin
                  err_sop_d = 1'b1;
               end
            end
            S_RECV: begin
               wr_en_s   = 1'b1;
               cnt_d     = cnt_next_s;
               err_sop_d = avs_s1_startofpacket;
               if (avs_s1_endofpacket) begin
                  err_len_d = (cnt_next_s != expected_len);
                  state_d   = S_IDLE;
               end else begin
                  state_d   = S_RECV;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // Byte index, completion pulse and saturating error count
   always_comb begin
      byte_idx_d   = byte_idx_q;
      frame_done_d = smp_hs_s && smp_last;
      err_cnt_d    = sat_add8(err_cnt_q, {1'b0, err_sop_d} + {1'b0, err_len_d});
      if (smp_hs_s) begin
         byte_idx_d = byte_idx_q + 2'd1;
      end else begin
         byte_idx_d = byte_idx_q;
      end
   end

   // State registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= 16'd0;
         byte_idx_q   <= 2'd0;
         err_sop_q    <= 1'b0;
         err_len_q    <= 1'b0;
         frame_done_q <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         byte_idx_q   <= byte_idx_d;
         err_sop_q    <= err_sop_d;
         err_len_q    <= err_len_d;
         frame_done_q <= frame_done_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign frame_done = frame_done_q;
   assign err_sop    = err_sop_q;
   assign err_len    = err_len_q;
   assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ai_stream_unpacker.sv
// Scoreboard bench for ai_stream_unpacker: expected bytes are queued when a
// word is accepted and compared as the DUT hands bytes out.
module tb_ai_stream_unpacker;

   logic        clk = 1'b0;
   logic        rst, enable;
   logic [15:0] expected_len;
   logic        avs_s1_valid, avs_s1_startofpacket, avs_s1_endofpacket, avs_s1_ready;
   logic [31:0] avs_s1_data;
   logic        smp_valid, smp_first, smp_last, smp_ready;
   logic [7:0]  smp_data;
   logic        frame_done, err_sop, err_len;
   logic [7:0]  err_cnt;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [9:0]  sb_q[$];
   bit          mon_on   = 1'b0;
   bit          exp_fd   = 1'b0;
   int          first_cyc, last_cyc, acc_cyc, t1_acc;
   bit          m_recv;
   logic [15:0] m_cnt;
   int          exp_errcnt;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ai_stream_unpacker #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .enable               (enable),
      .expected_len         (expected_len),
      .avs_s1_valid         (avs_s1_valid),
      .avs_s1_data          (avs_s1_data),
      .avs_s1_startofpacket (avs_s1_startofpacket),
      .avs_s1_endofpacket   (avs_s1_endofpacket),
      .avs_s1_ready         (avs_s1_ready),
      .smp_valid            (smp_valid),
      .smp_data             (smp_data),
      .smp_first            (smp_first),
      .smp_last             (smp_last),
      .smp_ready            (smp_ready),
      .frame_done           (frame_done),
      .err_sop              (err_sop),
      .err_len              (err_len),
      .err_cnt              (err_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference framing model: decides write/drop and error pulses per word
   task automatic model_word(input logic sop, input logic eop, output bit wr, output bit es, output bit el);
      wr = 1'b0; es = 1'b0; el = 1'b0;
      if (!m_recv) begin
         if (!sop) begin
            es = 1'b1;
         end else begin
            wr = 1'b1;
            m_cnt = 16'd4;
            if (eop) el = (m_cnt != expected_len);
            else     m_recv = 1'b1;
         end
      end else begin
         wr = 1'b1;
         if (sop) begin
            es = 1'b1;
            m_cnt = 16'd4;
         end else begin
            m_cnt = m_cnt + 16'd4;
         end
         if (eop) begin
            el = (m_cnt != expected_len);
            m_recv = 1'b0;
         end
      end
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send_word(input logic [31:0] d, input logic sop, input logic eop);
      int  waitc;
      bit  wr, es, el;
      avs_s1_valid = 1'b1;
      avs_s1_data = d;
      avs_s1_startofpacket = sop;
      avs_s1_endofpacket = eop;
      waitc = 0;
      @(negedge clk);
      while (!avs_s1_ready && waitc < 200) begin
         @(negedge clk);
         waitc++;
      end
      if (!avs_s1_ready) begin
         check_eq("ready_timeout", avs_s1_ready, 1);
         @(posedge clk); #1;
         avs_s1_valid = 1'b0;
         return;
      end
      model_word(sop, eop, wr, es, el);
      if (wr) begin
         for (int i = 0; i < 4; i++) sb_q.push_back({(sop && i == 0), (eop && i == 3), d[8*i +: 8]});
      end
      @(posedge clk); #1;
      acc_cyc = cyc;
      avs_s1_valid = 1'b0;
      exp_errcnt = exp_errcnt + int'(es) + int'(el);
      if (exp_errcnt > 255) exp_errcnt = 255;
      check_eq("err_sop", err_sop, es);
      check_eq("err_len", err_len, el);
      check_eq("err_cnt", err_cnt, exp_errcnt);
   endtask

   task automatic wait_drain();
      int k = 0;
      while (sb_q.size() != 0 && k < 500) begin
         @(negedge clk);
         k++;
      end
      check_eq("drain", sb_q.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // Output monitor: byte scoreboard and frame_done timing
   always @(negedge clk) begin
      logic [9:0] e;
      if (mon_on) begin
         check_eq("frame_done", frame_done, exp_fd);
         exp_fd = 1'b0;
         if (rst && smp_valid && smp_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_empty_on_byte", sb_q.size(), 1);
            end else begin
               e = sb_q.pop_front();
               check_eq("byte", {22'd0, smp_first, smp_last, smp_data}, {22'd0, e});
               exp_fd = e[8];
               if (e[9]) first_cyc = cyc;
               if (e[8]) last_cyc = cyc;
            end
         end
      end
   end

   initial begin
      int n;
      rst = 1'b0; enable = 1'b0; expected_len = 16'd8;
      avs_s1_valid = 1'b0; avs_s1_data = 32'd0;
      avs_s1_startofpacket = 1'b0; avs_s1_endofpacket = 1'b0;
      smp_ready = 1'b1;
      m_recv = 1'b0; m_cnt = 16'd0; exp_errcnt = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      mon_on = 1'b1;
      @(negedge clk);
      check_eq("rst_valid", smp_valid, 0);
      check_eq("rst_data", smp_data, 0);
      check_eq("rst_ready", avs_s1_ready, 0);
      check_eq("rst_errs", {err_sop, err_len, frame_done}, 0);
      check_eq("rst_err_cnt", err_cnt, 0);
      @(posedge clk); #1;
      enable = 1'b1;

      // Basic two-word packet, full-rate drain
      send_word(32'h44332211, 1'b1, 1'b0);
      t1_acc = acc_cyc;
      send_word(32'h88776655, 1'b0, 1'b1);
      wait_drain();
      check_eq("t1_latency", first_cyc - t1_acc, 0);
      check_eq("t1_span", last_cyc - first_cyc, 7);

      // Stray word while idle is dropped
      send_word(32'hDEADBEEF, 1'b0, 1'b0);
      @(negedge clk);
      check_eq("t2_no_valid", smp_valid, 0);
      @(posedge clk); #1;

      // Three-word packet against an 8-byte frame
      send_word(32'h03020100, 1'b1, 1'b0);
      send_word(32'h07060504, 1'b0, 1'b0);
      send_word(32'h0B0A0908, 1'b0, 1'b1);
      wait_drain();

      // Enable low blocks the sink
      enable = 1'b0;
      avs_s1_valid = 1'b1;
      @(negedge clk);
      check_eq("en_low_ready", avs_s1_ready, 0);
      @(posedge clk); #1;
      avs_s1_valid = 1'b0;
      enable = 1'b1;

      // Fill the FIFO with output stalled
      smp_ready = 1'b0;
      expected_len = 16'd68;
      for (int i = 0; i < 16; i++) send_word(32'hA0B0C0D0 ^ (i * 32'h01010101), (i == 0), 1'b0);
      avs_s1_valid = 1'b1;
      avs_s1_data = 32'h5A5A5A5A;
      @(negedge clk);
      check_eq("t4_full_ready", avs_s1_ready, 0);
      @(posedge clk); #1;
      avs_s1_valid = 1'b0;
      smp_ready = 1'b1;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (avs_s1_ready) break;
         n++;
      end
      check_eq("t4_ready_reassert", n, 4);
      @(posedge clk); #1;
      send_word(32'h5A5A5A5A, 1'b0, 1'b1);
      wait_drain();

      // Reset with three words buffered mid-packet
      smp_ready = 1'b0;
      expected_len = 16'd16;
      send_word(32'h11111111, 1'b1, 1'b0);
      send_word(32'h22222222, 1'b0, 1'b0);
      send_word(32'h33333333, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("t5_rst_ready", avs_s1_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      sb_q.delete();
      m_recv = 1'b0; m_cnt = 16'd0; exp_errcnt = 0;
      @(negedge clk);
      check_eq("t5_valid", smp_valid, 0);
      check_eq("t5_err_cnt", err_cnt, 0);
      @(posedge clk); #1;
      smp_ready = 1'b1;
      expected_len = 16'd8;
      send_word(32'hC3C2C1C0, 1'b1, 1'b0);
      send_word(32'hC7C6C5C4, 1'b0, 1'b1);
      wait_drain();

      // Error counter saturation
      for (int i = 0; i < 300; i++) send_word(i, 1'b0, 1'b0);
      check_eq("t6_sat", err_cnt, 255);
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
